// File: rtl/vga_frame_monitor.sv
// Passive VGA stream checker: rebuilds pixel coordinates from the sync edges,
// verifies line/frame timing, tracks sync lock and checksums every locked frame.
module vga_frame_monitor #(
  parameter int H_FIRST  = 216,
  parameter int H_ACTIVE = 800,
  parameter int H_TOTAL  = 1056,
  parameter int V_FIRST  = 27,
  parameter int V_ACTIVE = 600,
  parameter int V_TOTAL  = 628,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [7:0]  color_i,
  output logic [9:0]  pixel_x_o,
  output logic [9:0]  pixel_y_o,
  output logic [7:0]  pixel_color_o,
  output logic        pixel_valid_o,
  output logic        frame_start_o,
  output logic [15:0] frame_sum_o,
  output logic        sum_valid_o,
  output logic        locked_o,
  output logic        sync_error_o
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  localparam logic [10:0] H_LO   = 11'(H_FIRST);
  localparam logic [10:0] H_HI   = 11'(H_FIRST + H_ACTIVE);
  localparam logic [10:0] H_END  = 11'(H_FIRST + H_ACTIVE - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LO   = 10'(V_FIRST);
  localparam logic [9:0]  V_HI   = 10'(V_FIRST + V_ACTIVE);
  localparam logic [9:0]  V_END  = 10'(V_FIRST + V_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic        hsS1_q, vsS1_q, hsPrev_q, vsPrev_q;
  logic [7:0]  colS1_q, colS2_q;
  logic        hsEdge, vsEdge, lineBad, frameBad;
  logic [10:0] hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic        hSeen_q, vSeen_q, lineErr_q, lineErr_d;
  state_e      state_q, state_d;
  logic        isLocked, syncErr_q, syncErr_d;
  logic        inWin, pixValid_d, frameStart_d, lastPix_d;
  logic [9:0]  pixX_q, pixX_d, pixY_q, pixY_d;
  logic [7:0]  pixCol_q, pixCol_d;
  logic        pixValid_q, frameStart_q, lastPix_q, sumValid_q;
  logic [15:0] acc_q, acc_d, frameSum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsS1_q   <= ~SYNC_POL;
      vsS1_q   <= ~SYNC_POL;
      hsPrev_q <= ~SYNC_POL;
      vsPrev_q <= ~SYNC_POL;
      colS1_q  <= '0;
    end else begin
      hsS1_q   <= hsync_i;
      vsS1_q   <= vsync_i;
      hsPrev_q <= hsS1_q;
      vsPrev_q <= vsS1_q;
      colS1_q  <= color_i;
    end
  end

  assign hsEdge = (hsS1_q == SYNC_POL) && (hsPrev_q != SYNC_POL);
  assign vsEdge = (vsS1_q == SYNC_POL) && (vsPrev_q != SYNC_POL);

  // Counters hold the coordinates of the previous stage-1 sample, which is what the checks compare.
  always_comb begin
    hCnt_d = hCnt_q;
    if (hsEdge)
      hCnt_d = '0;
    else if (hCnt_q != '1)
      hCnt_d = hCnt_q + 11'd1;
    vCnt_d = vCnt_q;
    if (vsEdge)
      vCnt_d = '0;
    else if (hsEdge && vCnt_q != '1)
      vCnt_d = vCnt_q + 10'd1;
    lineBad  = hsEdge && hSeen_q && (hCnt_q != H_LAST);
    frameBad = vsEdge && vSeen_q && (vCnt_q != V_LAST);
    // A line error that knocks us out of LOCKED still counts against the frame in progress.
    lineErr_d = lineErr_q;
    if (vsEdge)
      lineErr_d = 1'b0;
    else if (lineBad)
      lineErr_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      colS2_q   <= '0;
      hSeen_q   <= 1'b0;
      vSeen_q   <= 1'b0;
      lineErr_q <= 1'b0;
    end else begin
      hCnt_q    <= hCnt_d;
      vCnt_q    <= vCnt_d;
      colS2_q   <= colS1_q;
      hSeen_q   <= hSeen_q | hsEdge;
      vSeen_q   <= vSeen_q | vsEdge;
      lineErr_q <= lineErr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      syncErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      syncErr_q <= syncErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (vsEdge) state_d = ACQUIRE;
      ACQUIRE: if (vsEdge && !frameBad && !lineBad && !lineErr_q) state_d = LOCKED;
      LOCKED:  if (lineBad || frameBad) state_d = ACQUIRE;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    isLocked  = (state_q == LOCKED);
    syncErr_d = isLocked && (lineBad || frameBad);
  end

  always_comb begin
    inWin        = (hCnt_q >= H_LO) && (hCnt_q < H_HI) && (vCnt_q >= V_LO) && (vCnt_q < V_HI);
    pixValid_d   = isLocked && inWin;
    frameStart_d = pixValid_d && (hCnt_q == H_LO) && (vCnt_q == V_LO);
    lastPix_d    = pixValid_d && (hCnt_q == H_END) && (vCnt_q == V_END);
    pixX_d       = pixX_q;
    pixY_d       = pixY_q;
    pixCol_d     = pixCol_q;
    acc_d        = acc_q;
    if (pixValid_d) begin
      pixX_d   = 10'(hCnt_q - H_LO);
      pixY_d   = vCnt_q - V_LO;
      pixCol_d = colS2_q;
      acc_d    = frameStart_d ? {8'h00, colS2_q} : acc_q + {8'h00, colS2_q};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pixX_q       <= '0;
      pixY_q       <= '0;
      pixCol_q     <= '0;
      pixValid_q   <= 1'b0;
      frameStart_q <= 1'b0;
      lastPix_q    <= 1'b0;
      acc_q        <= '0;
      frameSum_q   <= '0;
      sumValid_q   <= 1'b0;
    end else begin
      pixX_q       <= pixX_d;
      pixY_q       <= pixY_d;
      pixCol_q     <= pixCol_d;
      pixValid_q   <= pixValid_d;
      frameStart_q <= frameStart_d;
      lastPix_q    <= lastPix_d;
      acc_q        <= acc_d;
      frameSum_q   <= lastPix_q ? acc_q : frameSum_q;
      sumValid_q   <= lastPix_q;
    end
  end

  assign pixel_x_o     = pixX_q;
  assign pixel_y_o     = pixY_q;
  assign pixel_color_o = pixCol_q;
  assign pixel_valid_o = pixValid_q;
  assign frame_start_o = frameStart_q;
  assign frame_sum_o   = frameSum_q;
  assign sum_valid_o   = sumValid_q;
  assign locked_o      = isLocked;
  assign sync_error_o  = syncErr_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a shrunken 16x8 timing (8x4 active).
module tb_vga_frame_monitor;

  localparam int HF = 4, HA = 8, HT = 16, VF = 2, VA = 4, VT = 8;
  localparam logic POL = 1'b1;

  logic        clk, rst, hsync, vsync;
  logic [7:0]  color;
  logic [9:0]  pixelX, pixelY;
  logic [7:0]  pixelColor;
  logic        pixelValid, frameStart, sumValid, locked, syncError;
  logic [15:0] frameSum;

  int nVec = 0;
  int nMis = 0;

  bit         rampMode = 1'b0;
  logic [7:0] colorConst = 8'h00;
  int         curFrame = 0;

  int          validCnt = 0, sumCnt = 0, errCnt = 0, startCnt = 0, fsBad = 0, rampBad = 0;
  int          lastRise = 0, lastX = 0, lastY = 0;
  logic [15:0] lastSum = 16'h0;
  logic        prevLocked = 1'b0;

  typedef struct {
    string      name;
    int         nFrames;
    bit         ramp;
    logic [7:0] col;
    int         faultFrame;
    int         faultKind;
    int         expValid;
    int         expSums;
    int         expSum;
    int         expErr;
    int         expLocked;
    int         expRise;
    int         expX;
    int         expY;
    int         expStarts;
  } vec_t;

  vec_t vecs[6];

  vga_frame_monitor #(
    .H_FIRST(HF), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_FIRST(VF), .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync), .color_i(color),
    .pixel_x_o(pixelX), .pixel_y_o(pixelY), .pixel_color_o(pixelColor),
    .pixel_valid_o(pixelValid), .frame_start_o(frameStart), .frame_sum_o(frameSum),
    .sum_valid_o(sumValid), .locked_o(locked), .sync_error_o(syncError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder: tallies output activity between resets on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        validCnt = 0; sumCnt = 0; errCnt = 0; startCnt = 0; fsBad = 0; rampBad = 0;
        lastRise = 0; lastX = 0; lastY = 0; lastSum = 16'h0; prevLocked = 1'b0;
      end else begin
        if (pixelValid) begin
          validCnt++;
          lastX = int'(pixelX);
          lastY = int'(pixelY);
          if (rampMode && pixelColor != 8'(int'(pixelX) + HF)) rampBad++;
        end
        if (frameStart) begin
          startCnt++;
          if (!(pixelValid && pixelX == 10'd0 && pixelY == 10'd0)) fsBad++;
        end
        if (sumValid) begin
          sumCnt++;
          lastSum = frameSum;
        end
        if (syncError) errCnt++;
        if (locked && !prevLocked) lastRise = curFrame;
        prevLocked = locked;
      end
    end
  end

  function automatic vec_t mkVec(string n, int nf, bit rp, logic [7:0] c, int ff, int fk,
                                 int ev, int es, int esum, int ee, int el, int er,
                                 int ex, int ey, int est);
    vec_t v;
    v.name = n; v.nFrames = nf; v.ramp = rp; v.col = c; v.faultFrame = ff; v.faultKind = fk;
    v.expValid = ev; v.expSums = es; v.expSum = esum; v.expErr = ee; v.expLocked = el;
    v.expRise = er; v.expX = ex; v.expY = ey; v.expStarts = est;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic driveSamples(input int l, input int c0, input int n, input int hsLen);
    for (int c = c0; c < c0 + n; c++) begin
      hsync = (c < hsLen) ? POL : ~POL;
      vsync = (l == 0) ? POL : ~POL;
      color = rampMode ? 8'(c) : colorConst;
      @(posedge clk);
      #1;
    end
  endtask

  // kind 1: line 3 one cycle short; kind 2: frame one line short; kind 3: hsync stuck on the last line.
  task automatic driveFrame(input int kind);
    int nLines;
    nLines = (kind == 2) ? VT - 1 : VT;
    for (int l = 0; l < nLines; l++) begin
      if (kind == 1 && l == 3)
        driveSamples(l, 0, HT - 1, 2);
      else if (kind == 3 && l == VT - 1)
        driveSamples(l, 0, 2064, 2060);
      else
        driveSamples(l, 0, HT, 2);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    hsync = ~POL;
    vsync = ~POL;
    color = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    resetDut();
    rampMode = v.ramp;
    colorConst = v.col;
    for (int f = 1; f <= v.nFrames; f++) begin
      curFrame = f;
      driveFrame((f == v.faultFrame) ? v.faultKind : 0);
    end
    curFrame = v.nFrames + 1;
    driveSamples(0, 0, 4, 2);
    checkOutput({v.name, ".validCount"}, validCnt, v.expValid);
    checkOutput({v.name, ".sumPulses"}, sumCnt, v.expSums);
    checkOutput({v.name, ".frameSum"}, int'(lastSum), v.expSum);
    checkOutput({v.name, ".syncErrors"}, errCnt, v.expErr);
    checkOutput({v.name, ".locked"}, int'(locked), v.expLocked);
    checkOutput({v.name, ".lockRiseFrame"}, lastRise, v.expRise);
    checkOutput({v.name, ".lastX"}, lastX, v.expX);
    checkOutput({v.name, ".lastY"}, lastY, v.expY);
    checkOutput({v.name, ".frameStarts"}, startCnt, v.expStarts);
    checkOutput({v.name, ".frameStartAt00"}, fsBad, 0);
    if (v.ramp) checkOutput({v.name, ".rampColor"}, rampBad, 0);
  endtask

  initial begin
    vecs[0] = mkVec("nominal",    3, 1'b0, 8'hFF, 0, 0, 64, 2, 16'h1FE0, 0, 1, 2, 7, 3, 2);
    vecs[1] = mkVec("ramp",       3, 1'b1, 8'h00, 0, 0, 64, 2, 16'h00F0, 0, 1, 2, 7, 3, 2);
    vecs[2] = mkVec("shortLine",  5, 1'b0, 8'hFF, 3, 1, 80, 2, 16'h1FE0, 1, 1, 5, 7, 3, 3);
    vecs[3] = mkVec("shortFrame", 4, 1'b0, 8'h5A, 1, 2, 64, 2, 16'h0B40, 0, 1, 3, 7, 3, 2);
    vecs[4] = mkVec("stuckHsync", 4, 1'b0, 8'h03, 3, 3, 64, 2, 16'h0060, 1, 1, 5, 7, 3, 2);
    vecs[5] = mkVec("oneFrame",   1, 1'b0, 8'hFF, 0, 0,  0, 0, 16'h0000, 0, 1, 2, 0, 0, 0);

    rst = 1'b1;
    hsync = ~POL;
    vsync = ~POL;
    color = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.pixelValid", int'(pixelValid), 0);
    checkOutput("reset.locked", int'(locked), 0);
    checkOutput("reset.frameSum", int'(frameSum), 0);
    checkOutput("reset.syncError", int'(syncError), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Exact pipeline latency: one marked colour at pixel (0,0), then the checksum handoff.
    resetDut();
    rampMode = 1'b0;
    colorConst = 8'h00;
    curFrame = 1; driveFrame(0);
    curFrame = 2; driveFrame(0);
    curFrame = 3;
    driveSamples(0, 0, HT, 2);
    driveSamples(1, 0, HT, 2);
    driveSamples(2, 0, 4, 2);
    colorConst = 8'hC3;
    driveSamples(2, 4, 1, 2);
    colorConst = 8'h00;
    checkOutput("lat.t0.valid", int'(pixelValid), 0);
    driveSamples(2, 5, 1, 2);
    checkOutput("lat.t1.valid", int'(pixelValid), 0);
    driveSamples(2, 6, 1, 2);
    checkOutput("lat.t2.valid", int'(pixelValid), 1);
    checkOutput("lat.t2.x", int'(pixelX), 0);
    checkOutput("lat.t2.y", int'(pixelY), 0);
    checkOutput("lat.t2.color", int'(pixelColor), 8'hC3);
    checkOutput("lat.t2.frameStart", int'(frameStart), 1);
    driveSamples(2, 7, 1, 2);
    checkOutput("lat.t3.color", int'(pixelColor), 0);
    checkOutput("lat.t3.x", int'(pixelX), 1);
    checkOutput("lat.t3.frameStart", int'(frameStart), 0);
    driveSamples(2, 8, HT - 8, 2);
    driveSamples(3, 0, HT, 2);
    driveSamples(4, 0, HT, 2);
    driveSamples(5, 0, 12, 2);
    driveSamples(5, 12, 1, 2);
    checkOutput("sum.u1.sumValid", int'(sumValid), 0);
    driveSamples(5, 13, 1, 2);
    checkOutput("sum.u2.valid", int'(pixelValid), 1);
    checkOutput("sum.u2.x", int'(pixelX), 7);
    checkOutput("sum.u2.y", int'(pixelY), 3);
    checkOutput("sum.u2.sumValid", int'(sumValid), 0);
    driveSamples(5, 14, 1, 2);
    checkOutput("sum.u3.sumValid", int'(sumValid), 1);
    checkOutput("sum.u3.frameSum", int'(frameSum), 8'hC3);
    checkOutput("sum.u3.valid", int'(pixelValid), 0);
    checkOutput("sum.u3.holdX", int'(pixelX), 7);
    checkOutput("sum.u3.holdY", int'(pixelY), 3);
    driveSamples(5, 15, 1, 2);
    checkOutput("sum.u4.sumValid", int'(sumValid), 0);

    // Asynchronous reset in the middle of a locked frame, then full reacquisition.
    resetDut();
    colorConst = 8'hFF;
    curFrame = 1; driveFrame(0);
    curFrame = 2; driveFrame(0);
    curFrame = 3;
    for (int l = 0; l < 3; l++) driveSamples(l, 0, HT, 2);
    driveSamples(3, 0, 8, 2);
    checkOutput("midrst.before.valid", int'(pixelValid), 1);
    checkOutput("midrst.before.locked", int'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst.pixelX", int'(pixelX), 0);
    checkOutput("midrst.pixelY", int'(pixelY), 0);
    checkOutput("midrst.pixelColor", int'(pixelColor), 0);
    checkOutput("midrst.pixelValid", int'(pixelValid), 0);
    checkOutput("midrst.frameStart", int'(frameStart), 0);
    checkOutput("midrst.frameSum", int'(frameSum), 0);
    checkOutput("midrst.sumValid", int'(sumValid), 0);
    checkOutput("midrst.locked", int'(locked), 0);
    checkOutput("midrst.syncError", int'(syncError), 0);
    driveSamples(3, 8, HT - 8, 2);
    rst = 1'b0;
    for (int l = 4; l < VT; l++) driveSamples(l, 0, HT, 2);
    curFrame = 4; driveFrame(0);
    checkOutput("midrst.noLockYet", int'(locked), 0);
    curFrame = 5;
    driveSamples(0, 0, 4, 2);
    checkOutput("midrst.relocked", int'(locked), 1);
    checkOutput("midrst.lockRiseFrame", lastRise, 5);
    checkOutput("midrst.syncErrors", errCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
